pipelined_bla_subtractor: RTL and testbench
===========================================

Name: pipelined_bla_subtractor

Overview:
- Parametrised N-bit borrow-look-ahead subtractor for the CPU datapath.
- Computes diff = a - b - bin.
- The operand is split into STAGES equal slices; each slice is resolved with borrow look-ahead inside one pipeline stage, and the slice borrow is registered into the next stage.
- Valid/ready handshakes on both sides; produces ALU status flags (zero, negative, signed overflow) alongside the difference.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH % STAGES must be 0.
- STAGES, 4, number of pipeline stages (= latency in cycles); 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b, bin are valid this cycle.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in to the least-significant slice.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out of the MSB; 1 when unsigned a < b + bin.
- zero  output  1  diff == 0.
- neg  output  1  diff[WIDTH-1].
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- SLICE = WIDTH/STAGES. Stage k (k = 0..STAGES-1) resolves bits [k*SLICE +: SLICE].
  - Slice generate: g_i = ~a_i & b_i. Slice propagate: p_i = ~(a_i ^ b_i).
  - Slice borrow: look-ahead from the stage's registered borrow-in, with no ripple chain across the slice.
  - diff_i = a_i ^ b_i ^ borrow_i.
- Operand skew: slices not yet consumed travel down the pipeline with their op. Result bits already computed travel with the op. A running zero accumulator also travels with the op.
- One valid bit per stage.
- Global advance = ~out_valid | out_ready.
  - When advance=1: every stage register loads from its predecessor, including the valid bit. Stage 0 loads from the ports.
  - When advance=0: all stage registers hold.
- in_ready = advance, which is combinational from out_valid/out_ready.
  - An op is accepted only on a cycle where in_valid & in_ready.
  - Otherwise a bubble (valid=0) enters stage 0.
- Latency: an op accepted at edge n appears with out_valid=1 after edge n+STAGES-1, when there is no stall.
  - Back-to-back throughput: 1 op/cycle.
- The output register is the last stage; diff/bout/zero/neg/ovf are registered outputs.
  - They hold stable while out_valid & ~out_ready.
  - Outputs are don't-care when out_valid=0, but must not change while a stalled result is presented.
- Flags are computed for the complete WIDTH-bit result in the last stage:
  - zero = AND of per-slice zero terms.
  - neg = MSB of diff.
  - ovf uses the MSBs of a, b and diff carried to the last stage.
- Simultaneous accept and drain in the same cycle is legal; no op is lost or duplicated; ordering is strictly FIFO.
- Reset (asynchronous, any time, including mid-operation):
  - all stage valid bits, diff, bout, zero, neg and ovf go to 0 immediately;
  - in-flight ops are discarded;
  - in_ready=1 while reset is deasserted and out_valid=0.
- STAGES=1 degenerates to a full-width look-ahead with a single registered output, latency 1.
- No internal overflow of borrow: the borrow-out of the final slice is bout.

Test Plan:
- WIDTH=32, STAGES=4. a=0x00000005, b=0x00000003, bin=0, out_ready=1 -> exactly 4 cycles later diff=0x00000002, bout=0, zero=0, neg=0, ovf=0.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, neg=1, ovf=0. This checks that the borrow propagates through all 4 stage registers.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, neg=0, bout=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, bout=1.
- a=b=0x00001234: with bin=0 -> zero=1, bout=0. With bin=1 -> diff=0xFFFFFFFF, bout=1, zero=0.
- Stream 6 ops back-to-back with out_ready=0 for cycles 5-7:
  - in_ready=0 during the stall;
  - no result changes while stalled;
  - all 6 results emerge in order;
  - no duplicates.
- Assert reset while 3 ops are in flight -> out_valid=0 and all outputs=0 asynchronously. After release, a new op a=10, b=4 yields diff=6 with 4-cycle latency and no stale results.
- Rebuild with WIDTH=1, STAGES=1: exhaustively drive all 8 (a, b, bin) combinations. Expected results:
  - diff = a^b^bin;
  - bout = (~a&b) | (~(a^b)&bin);
  - each result arrives 1 cycle after acceptance.

Source files
------------

// File: rtl/pipelined_bla_subtractor.sv
// Pipelined borrow-look-ahead subtractor: diff = a - b - bin, one WIDTH/STAGES slice per stage,
// with zero/negative/signed-overflow flags registered alongside the result.
module pipelined_bla_subtractor #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int unsigned SLICE = WIDTH / STAGES;

    // Returns {borrow_out, diff}. Every borrow is a flat sum of products, so no ripple chain.
    function automatic logic [SLICE:0] bla_slice(input logic [SLICE-1:0] a_s,
                                                 input logic [SLICE-1:0] b_s,
                                                 input logic             cin);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   bor;
        logic             t;
        g = ~a_s & b_s;
        p = ~(a_s ^ b_s);
        for (int i = 0; i <= int'(SLICE); i++) begin
            t = cin;
            for (int m = 0; m < i; m++) t = t & p[m];
            bor[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                bor[i] = bor[i] | t;
            end
        end
        return {bor[SLICE], a_s ^ b_s ^ bor[SLICE-1:0]};
    endfunction

    logic w_advance;

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed by earlier stages (the MSB always stays on top).
        localparam int unsigned SRCW = WIDTH - k * SLICE;

        logic [SRCW-1:0]  w_src_a;
        logic [SRCW-1:0]  w_src_b;
        logic [WIDTH-1:0] w_src_diff;
        logic [WIDTH-1:0] w_nxt_diff;
        logic             w_src_borrow;
        logic             w_src_zero;
        logic             w_src_valid;
        logic [SLICE:0]   w_res;

        logic             r_valid;
        logic             r_borrow;
        logic             r_zero;
        logic [WIDTH-1:0] r_diff;

        if (k == 0) begin : g_head
            assign w_src_a      = a;
            assign w_src_b      = b;
            assign w_src_diff   = '0;
            assign w_src_borrow = bin;
            assign w_src_zero   = 1'b1;
            assign w_src_valid  = in_valid;
        end else begin : g_body
            assign w_src_a      = g_stage[k-1].g_carry.r_a;
            assign w_src_b      = g_stage[k-1].g_carry.r_b;
            assign w_src_diff   = g_stage[k-1].r_diff;
            assign w_src_borrow = g_stage[k-1].r_borrow;
            assign w_src_zero   = g_stage[k-1].r_zero;
            assign w_src_valid  = g_stage[k-1].r_valid;
        end

        assign w_res = bla_slice(w_src_a[SLICE-1:0], w_src_b[SLICE-1:0], w_src_borrow);

        always_comb begin
            w_nxt_diff                   = w_src_diff;
            w_nxt_diff[k*SLICE +: SLICE] = w_res[SLICE-1:0];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid  <= 1'b0;
                r_borrow <= 1'b0;
                r_zero   <= 1'b0;
                r_diff   <= '0;
            end else if (w_advance) begin
                r_valid  <= w_src_valid;
                r_borrow <= w_res[SLICE];
                r_zero   <= w_src_zero & ~|w_res[SLICE-1:0];
                r_diff   <= w_nxt_diff;
            end
        end

        if (k < STAGES - 1) begin : g_carry
            logic [SRCW-SLICE-1:0] r_a;
            logic [SRCW-SLICE-1:0] r_b;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_src_a[SRCW-1:SLICE];
                    r_b <= w_src_b[SRCW-1:SLICE];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= (w_src_a[SRCW-1] ^ w_src_b[SRCW-1]) &
                             (w_nxt_diff[WIDTH-1] ^ w_src_a[SRCW-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign diff      = g_stage[STAGES-1].r_diff;
    assign bout      = g_stage[STAGES-1].r_borrow;
    assign zero      = g_stage[STAGES-1].r_zero;
    assign neg       = g_stage[STAGES-1].r_diff[WIDTH-1];
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: tb/tb_pipelined_bla_subtractor.sv
// Directed bench: 32-bit/4-stage subtractor vectors, stall, async reset, plus a 1-bit/1-stage copy.
module tb_pipelined_bla_subtractor;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_a;
    logic        s_b;
    logic        s_bin;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_diff;
    logic        s_bout;
    logic        s_zero;
    logic        s_neg;
    logic        s_ovf;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_bla_subtractor #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    pipelined_bla_subtractor #(.WIDTH(1), .STAGES(1)) u_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .bin       (s_bin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .diff      (s_diff),
        .bout      (s_bout),
        .zero      (s_zero),
        .neg       (s_neg),
        .ovf       (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        a         = v.a;
        b         = v.b;
        bin       = v.bin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, lat, 4);
        chk({name, " diff"}, diff, v.diff);
        chk({name, " bout"}, bout, v.bout);
        chk({name, " zero"}, zero, v.zero);
        chk({name, " neg"}, neg, v.neg);
        chk({name, " ovf"}, ovf, v.ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    vec_t        vecs [9];
    logic [31:0] st_a [6];
    logic [31:0] st_b [6];
    logic        st_bin [6];
    logic [32:0] q [$];

    initial begin
        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h00001234, 32'h00001234, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h00001234, 32'h00001234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h12345678, 32'h02040608, 1'b1, 32'h1030506F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};

        st_a[0] = 32'h00000010; st_b[0] = 32'h00000001; st_bin[0] = 1'b0;
        st_a[1] = 32'hFFFF0000; st_b[1] = 32'h0000FFFF; st_bin[1] = 1'b1;
        st_a[2] = 32'h00000000; st_b[2] = 32'h00000000; st_bin[2] = 1'b1;
        st_a[3] = 32'h12345678; st_b[3] = 32'h12345678; st_bin[3] = 1'b0;
        st_a[4] = 32'h80000000; st_b[4] = 32'h7FFFFFFF; st_bin[4] = 1'b0;
        st_a[5] = 32'hDEADBEEF; st_b[5] = 32'h01234567; st_bin[5] = 1'b1;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        bin         = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        s_a         = 1'b0;
        s_b         = 1'b0;
        s_bin       = 1'b0;

        @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset diff", diff, 0);
        chk("reset flags", {bout, zero, neg, ovf}, 0);
        chk("reset small out_valid", s_out_valid, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Six back-to-back ops with the consumer stalled on cycles 5..7.
        idle(2);
        begin
            int sent;
            int got;
            logic [32:0] m;
            sent = 0;
            got  = 0;
            for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 5 && cyc <= 7);
                in_valid  = (sent < 6);
                if (sent < 6) begin
                    a   = st_a[sent];
                    b   = st_b[sent];
                    bin = st_bin[sent];
                end
                #1;
                if (cyc >= 5 && cyc <= 7) begin
                    chk("stall in_ready", in_ready, 0);
                    chk("stall out_valid", out_valid, 1);
                    if (q.size() > 0) chk("stall hold diff", diff, q[0][31:0]);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("stream spurious out_valid", out_valid, 0);
                    end else begin
                        chk($sformatf("stream op%0d diff", got), diff, q[0][31:0]);
                        chk($sformatf("stream op%0d bout", got), bout, q[0][32]);
                        void'(q.pop_front());
                        got++;
                    end
                end
                if (in_valid && in_ready) begin
                    m = {1'b0, a} - {1'b0, b} - {32'd0, bin};
                    q.push_back(m);
                    sent++;
                end
            end
            chk("stream result count", got, 6);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("stream no duplicate", out_valid, 0);
        end

        // Reset with one result presented and three more in flight.
        idle(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'h00000100 + 32'(i);
            b        = 32'h00000001;
            bin      = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("pre-reset out_valid", out_valid, 1);
        chk("pre-reset diff", diff, 32'h000000FF);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset diff", diff, 0);
        chk("async reset flags", {bout, zero, neg, ovf}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post-reset no stale", out_valid, 0);
        end
        run_op("after reset", '{32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0});
        idle(1);

        // 1-bit, 1-stage instance: all eight input combinations, one-cycle latency.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic       ed;
            logic       eb;
            v  = 3'(i);
            ed = v[2] ^ v[1] ^ v[0];
            eb = (~v[2] & v[1]) | (~(v[2] ^ v[1]) & v[0]);
            @(negedge clk);
            s_a        = v[2];
            s_b        = v[1];
            s_bin      = v[0];
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("small %0d out_valid", i), s_out_valid, 1);
            chk($sformatf("small %0d diff", i), s_diff, ed);
            chk($sformatf("small %0d bout", i), s_bout, eb);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("small drained", s_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
